// File: rtl/lock_dialer_if.sv
// Signal bundle between lock_dialer and its surroundings: the host
// request/status handshake plus the lock's step commands and feedback.
// The slave modport is the dialer's view; master is the harness/host view.
interface lock_dialer_if #(
    parameter int MSB = 6
);
    // Host side
    logic         start;
    logic         abort;
    logic [MSB:0] comb0;
    logic [MSB:0] comb1;
    logic [MSB:0] comb2;
    logic         busy;
    logic         done;
    logic         success;
    logic         error;

    // Lock side
    logic [MSB:0] position;
    logic         open;
    logic         up;
    logic         down;

    modport slave (
        input  start, abort, comb0, comb1, comb2, position, open,
        output up, down, busy, done, success, error
    );

    modport master (
        output start, abort, comb0, comb1, comb2, position, open,
        input  up, down, busy, done, success, error
    );
endinterface

// File: rtl/lock_dialer.sv
// Dials a three-number combination into the lock one notch at a time:
// clockwise onto comb0, counterclockwise onto comb1, clockwise onto comb2,
// then waits a bounded time for the lock to report open.
module lock_dialer #(
    parameter int MSB       = 6,
    parameter int OPEN_WAIT = 4
) (
    input logic        clock,
    input logic        reset,
    lock_dialer_if.slave bus
);

    localparam int WW = (OPEN_WAIT > 0) ? $clog2(OPEN_WAIT + 1) : 1;

    typedef logic [MSB:0]   pos_t;
    typedef logic [MSB+1:0] cnt_t;
    typedef logic [WW-1:0]  wait_t;

    // One full revolution; stepcnt needs one extra bit to hold it.
    localparam cnt_t  REV      = cnt_t'(1) << (MSB + 1);
    localparam cnt_t  CNT_ONE  = cnt_t'(1);
    localparam wait_t WAIT_ONE = wait_t'(1);
    localparam wait_t WAIT_MAX = wait_t'(OPEN_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_CHECK,
        S_WAITOPEN,
        S_DONE
    } state_e;

    state_e      state_q,   state_d;
    logic [1:0]  phase_q,   phase_d;
    cnt_t        stepcnt_q, stepcnt_d;
    wait_t       waitcnt_q, waitcnt_d;
    pos_t        tgt0_q,    tgt0_d;
    pos_t        tgt1_q,    tgt1_d;
    pos_t        tgt2_q,    tgt2_d;
    logic        up_q,      up_d;
    logic        down_q,    down_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        success_q, success_d;
    logic        error_q,   error_d;

    pos_t        target;

    // Target for the phase currently being dialed.
    always_comb begin
        target = tgt2_q;
        case (phase_q)
            2'd0:    target = tgt0_q;
            2'd1:    target = tgt1_q;
            default: target = tgt2_q;
        endcase
    end

    // Next-state and registered-output computation for the dialing FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        stepcnt_d = stepcnt_q;
        waitcnt_d = waitcnt_q;
        tgt0_d    = tgt0_q;
        tgt1_d    = tgt1_q;
        tgt2_d    = tgt2_q;
        success_d = success_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tgt0_d    = bus.comb0;
                    tgt1_d    = bus.comb1;
                    tgt2_d    = bus.comb2;
                    success_d = 1'b0;
                    error_d   = 1'b0;
                    phase_d   = 2'd0;
                    stepcnt_d = '0;
                    state_d   = S_STEP;
                end
            end
            S_STEP: begin
                stepcnt_d = stepcnt_q + CNT_ONE;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Match is tested before the revolution limit so that a
                // full 2**(MSB+1)-step revolution still lands successfully.
                if (bus.position == target) begin
                    if (phase_q != 2'd2) begin
                        phase_d   = phase_q + 2'd1;
                        stepcnt_d = '0;
                        state_d   = S_STEP;
                    end else begin
                        waitcnt_d = '0;
                        state_d   = S_WAITOPEN;
                    end
                end else if (stepcnt_q == REV) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_WAITOPEN: begin
                if (bus.open) begin
                    success_d = 1'b1;
                    state_d   = S_DONE;
                end else if (waitcnt_q == WAIT_MAX) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    waitcnt_d = waitcnt_q + WAIT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition above, including a CHECK match
        // or a timeout decided in the same cycle; status flags are held.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            success_d = success_q;
            error_d   = error_q;
        end

        // Outputs are decoded from the next state so that, once registered,
        // they line up exactly with the state they belong to.
        up_d   = (state_d == S_STEP) && (phase_d != 2'd1);
        down_d = (state_d == S_STEP) && (phase_d == 2'd1);
        busy_d = (state_d == S_STEP)   || (state_d == S_SETTLE) ||
                 (state_d == S_CHECK)  || (state_d == S_WAITOPEN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            stepcnt_q <= '0;
            waitcnt_q <= '0;
            tgt0_q    <= '0;
            tgt1_q    <= '0;
            tgt2_q    <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stepcnt_q <= stepcnt_d;
            waitcnt_q <= waitcnt_d;
            tgt0_q    <= tgt0_d;
            tgt1_q    <= tgt1_d;
            tgt2_q    <= tgt2_d;
            up_q      <= up_d;
            down_q    <= down_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            success_q <= success_d;
            error_q   <= error_d;
        end
    end

    assign bus.up      = up_q;
    assign bus.down    = down_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.success = success_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_lock_dialer.sv
// Self-checking bench for lock_dialer. A simple lock model follows the
// up/down pulses; expected pulse counts, outcome and latency come from the
// dialing rules computed arithmetically, independent of the FSM.
module tb_lock_dialer;

    localparam int MSB       = 6;
    localparam int OPEN_WAIT = 4;
    localparam int N         = 1 << (MSB + 1);

    typedef logic [MSB:0] pos_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lock_dialer_if #(.MSB(MSB)) bus ();

    lock_dialer #(.MSB(MSB), .OPEN_WAIT(OPEN_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- lock model ----------------
    int   lock_pos  = 0;
    logic load_req  = 1'b0;
    int   load_val  = 0;
    logic stuck     = 1'b0;
    int   stuck_val = 0;
    logic armed     = 1'b0;
    int   secret2   = 0;

    always @(posedge clock) begin
        if (load_req)          lock_pos <= load_val;
        else if (bus.up)       lock_pos <= (lock_pos + 1) % N;
        else if (bus.down)     lock_pos <= (lock_pos + N - 1) % N;
    end

    assign bus.position = stuck ? pos_t'(stuck_val) : pos_t'(lock_pos);
    assign bus.open     = armed && !stuck && (lock_pos == secret2);

    // ---------------- monitor ----------------
    int cyc        = 0;
    int pdir[$];
    int pcyc[$];
    int done_total = 0;
    int done_cyc   = 0;
    int overlap    = 0;

    always @(negedge clock) begin
        cyc++;
        if (bus.up === 1'b1 && bus.down === 1'b1) overlap++;
        if (bus.up === 1'b1) begin
            pdir.push_back(1);
            pcyc.push_back(cyc);
        end else if (bus.down === 1'b1) begin
            pdir.push_back(-1);
            pcyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    // ---------------- checking ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Clockwise steps from 'from' to 'to'; zero distance means a full turn.
    function automatic int fwd(input int from, input int to);
        int d;
        d = ((to - from) % N + N) % N;
        return (d == 0) ? N : d;
    endfunction

    // Split the pulse log from index 'from' into direction runs.
    task automatic analyse(input int from, output int nr, output int r0,
                           output int r1, output int r2, output int gaps,
                           output int last);
        nr = 0; r0 = 0; r1 = 0; r2 = 0; gaps = 0; last = 0;
        for (int i = from; i < pdir.size(); i++) begin
            if (i > from && (pcyc[i] - pcyc[i-1]) != 3) gaps++;
            if (i == from || pdir[i] != pdir[i-1]) nr++;
            case (nr)
                1:       r0 += pdir[i];
                2:       r1 += pdir[i];
                3:       r2 += pdir[i];
                default: ;
            endcase
            last = pcyc[i];
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_up"},      32'(bus.up),      0);
        check({tag, "_down"},    32'(bus.down),    0);
        check({tag, "_busy"},    32'(bus.busy),    0);
        check({tag, "_done"},    32'(bus.done),    0);
        check({tag, "_success"}, 32'(bus.success), 0);
        check({tag, "_error"},   32'(bus.error),   0);
    endtask

    task automatic set_pos(input int v);
        load_req = 1'b1;
        load_val = v;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int dbase);
        for (int k = 0; k < 2000 && done_total == dbase; k++) tick();
    endtask

    // Full dial with optional start pulse and comb1 change in phase 0.
    task automatic dial(input int c0, input int c1, input int c2, input int s2,
                        input bit mid_start, input bit mid_comb, input string tag);
        int  from, dbase, p0, nr, r0, r1, r2, gaps, last;
        bit  exp_ok;
        p0      = lock_pos;
        from    = pdir.size();
        dbase   = done_total;
        exp_ok  = (c2 == s2);
        armed   = 1'b1;
        secret2 = s2;
        bus.comb0 = pos_t'(c0);
        bus.comb1 = pos_t'(c1);
        bus.comb2 = pos_t'(c2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 1);
        for (int k = 0; k < 2000 && done_total == dbase; k++) begin
            if (k == 20) begin
                if (mid_start) bus.start = 1'b1;
                if (mid_comb)  bus.comb1 = pos_t'((c1 + 37) % N);
            end
            if (k == 21) bus.start = 1'b0;
            tick();
        end
        check({tag, "_done_seen"}, 32'(done_total - dbase), 1);
        check({tag, "_success"},   32'(bus.success), 32'(exp_ok));
        check({tag, "_error"},     32'(bus.error),   32'(!exp_ok));
        repeat (3) tick();
        check({tag, "_one_done"},  32'(done_total - dbase), 1);
        check({tag, "_idle_busy"}, 32'(bus.busy), 0);
        check({tag, "_flag_hold"}, 32'(bus.success), 32'(exp_ok));
        analyse(from, nr, r0, r1, r2, gaps, last);
        check({tag, "_runs"},   32'(nr), 3);
        check({tag, "_ph0"},    32'(r0), 32'(fwd(p0, c0)));
        check({tag, "_ph1"},    32'(r1), 32'(-fwd(c1, c0)));
        check({tag, "_ph2"},    32'(r2), 32'(fwd(c1, c2)));
        check({tag, "_gaps"},   32'(gaps), 0);
        check({tag, "_latency"}, 32'(done_cyc - last), exp_ok ? 4 : OPEN_WAIT + 4);
        check({tag, "_overlap"}, 32'(overlap), 0);
    endtask

    initial begin
        int from, dbase, nr, r0, r1, r2, gaps, last, downs, need;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.comb0 = '0;
        bus.comb1 = '0;
        bus.comb2 = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check_all_low("reset");
        reset = 1'b0;
        tick();

        // Nominal dial and target-equals-start full revolution
        set_pos(0);
        dial(12, 21, 15, 15, 1'b0, 1'b0, "nominal");
        set_pos(12);
        dial(12, 21, 15, 15, 1'b0, 1'b0, "same_start");

        // Stuck position: one full clockwise revolution, then timeout
        stuck     = 1'b1;
        stuck_val = 5;
        from      = pdir.size();
        dbase     = done_total;
        bus.comb0 = pos_t'(12);
        bus.comb1 = pos_t'(21);
        bus.comb2 = pos_t'(15);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(dbase);
        check("stuck_done",    32'(done_total - dbase), 1);
        check("stuck_error",   32'(bus.error),   1);
        check("stuck_success", 32'(bus.success), 0);
        analyse(from, nr, r0, r1, r2, gaps, last);
        check("stuck_runs",    32'(nr), 1);
        check("stuck_ups",     32'(r0), N);
        check("stuck_latency", 32'(done_cyc - last), 3);
        stuck = 1'b0;
        repeat (2) tick();

        // Wrong final number: all phases complete, open never seen
        set_pos(0);
        dial(12, 21, 16, 15, 1'b0, 1'b0, "wrong");

        // Abort during phase 1, then re-dial from the current lock position
        from      = pdir.size();
        dbase     = done_total;
        bus.comb0 = pos_t'(12);
        bus.comb1 = pos_t'(21);
        bus.comb2 = pos_t'(15);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        downs = 0;
        for (int k = 0; k < 2000 && downs < 5; k++) begin
            tick();
            downs = 0;
            for (int i = from; i < pdir.size(); i++) if (pdir[i] < 0) downs++;
        end
        check("abort_reached_ph1", 32'(downs >= 5), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_all_low("abort");
        repeat (5) tick();
        check("abort_no_done", 32'(done_total - dbase), 0);
        dial(12, 21, 15, 15, 1'b0, 1'b0, "redial");

        // Start pulse and comb1 change while busy are ignored
        set_pos(40);
        dial(12, 21, 15, 15, 1'b1, 1'b1, "busy_start");

        // Randomized combinations from random lock positions
        for (int t = 0; t < 6; t++) begin
            int c0, c1, c2, s2;
            c0 = $urandom % N;
            c1 = $urandom % N;
            c2 = $urandom % N;
            s2 = ($urandom % 2 == 0) ? c2 : (c2 + 1) % N;
            set_pos($urandom % N);
            dial(c0, c1, c2, s2, 1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        // Reset in the middle of phase 2
        set_pos(0);
        from      = pdir.size();
        bus.comb0 = pos_t'(12);
        bus.comb1 = pos_t'(21);
        bus.comb2 = pos_t'(15);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        need = fwd(0, 12) + fwd(21, 12) + 5;
        for (int k = 0; k < 3000 && (pdir.size() - from) < need; k++) tick();
        check("rst_reached_ph2", 32'((pdir.size() - from) >= need), 1);
        reset = 1'b1;
        tick();
        check_all_low("mid_reset");
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_busy", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
